// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge: turns the core's pipelined DX/WB data port into a valid/ready
// request plus response bus transaction with byte strobes and load extension.
// Ports:
//   clk, reset_n          clock and synchronous active-low reset
//   dmem_*                core side: request in DX, store data in WB, rdata/wait/badmem back
//   bus_req_*             request channel (valid/ready, word address, strobes, data)
//   bus_resp_*            response channel (valid, raw word, error)
module vscale_dmem_bridge (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_wait,
    output logic        dmem_badmem_e,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_wen,
    output logic [31:0] bus_req_addr,
    output logic [3:0]  bus_req_wstrb,
    output logic [31:0] bus_req_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_MISAL = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        wen_q, wen_d;
    logic        first_q, first_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_req;
    logic        resp_done;
    logic        accept;
    logic        misal_in;
    logic [31:0] wsrc;
    logic [31:0] wrep;
    logic [3:0]  strb;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign in_req    = (state_q == S_REQ);
    assign resp_done = (state_q == S_RESP) && bus_resp_valid;
    assign dmem_wait = in_req || ((state_q == S_RESP) && !bus_resp_valid);
    assign accept    = dmem_en && !dmem_wait;

    // Alignment check on the incoming DX request.
    always_comb begin
        misal_in = 1'b0;
        case (dmem_size[1:0])
            2'b00:   misal_in = 1'b0;
            2'b01:   misal_in = dmem_addr[0];
            default: misal_in = (dmem_addr[1:0] != 2'b00);
        endcase
    end

    // Store data arrives in WB, i.e. on the first REQ cycle only; later
    // REQ cycles replay the captured copy so the bus sees stable data.
    assign wsrc = first_q ? dmem_wdata_delayed : wdata_q;

    always_comb begin
        wrep = wsrc;
        strb = 4'b1111;
        case (size_q[1:0])
            2'b00: begin
                wrep = {4{wsrc[7:0]}};
                strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                wrep = {2{wsrc[15:0]}};
                strb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                wrep = wsrc;
                strb = 4'b1111;
            end
        endcase
    end

    assign bus_req_valid = in_req;
    assign bus_req_wen   = in_req & wen_q;
    assign bus_req_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_req_wstrb = (in_req && wen_q) ? strb : 4'd0;
    assign bus_req_wdata = in_req ? wrep : 32'd0;

    // Load extension: bring the addressed lane down to bit 0, then
    // sign- or zero-extend depending on the unsigned bit of funct3.
    assign shifted = bus_resp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext = bus_resp_rdata;
        case (size_q[1:0])
            2'b00:   ext = {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ext = {{16{~size_q[2] & shifted[15]}}, shifted[15:0]};
            default: ext = bus_resp_rdata;
        endcase
    end

    assign dmem_rdata    = resp_done ? ext : rdata_q;
    assign dmem_badmem_e = (state_q == S_MISAL) || (resp_done && bus_resp_err);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wen_d   = wen_q;
        first_d = 1'b0;
        wdata_d = (in_req && first_q) ? dmem_wdata_delayed : wdata_q;
        rdata_d = resp_done ? ext : rdata_q;
        case (state_q)
            S_REQ:   if (bus_req_ready) state_d = S_RESP;
            S_RESP:  if (bus_resp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Accept can only fire when not stalling, which also covers the
        // back-to-back case out of a completing RESP or MISAL cycle.
        if (accept) begin
            addr_d  = dmem_addr;
            size_d  = dmem_size;
            wen_d   = dmem_wen;
            state_d = misal_in ? S_MISAL : S_REQ;
            first_d = !misal_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            size_q  <= 3'd0;
            wen_q   <= 1'b0;
            first_q <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wen_q   <= wen_d;
            first_q <= first_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// tb_vscale_dmem_bridge: directed vector table, hand-written corner sequences
// and randomized transactions checked against an arithmetic reference model.
module tb_vscale_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dmem_en;
    logic        dmem_wen;
    logic [2:0]  dmem_size;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata_delayed;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        dmem_badmem_e;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_wen;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rdata = 32'd0;

    always #5 clk = ~clk;

    vscale_dmem_bridge dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .dmem_en            (dmem_en),
        .dmem_wen           (dmem_wen),
        .dmem_size          (dmem_size),
        .dmem_addr          (dmem_addr),
        .dmem_wdata_delayed (dmem_wdata_delayed),
        .dmem_rdata         (dmem_rdata),
        .dmem_wait          (dmem_wait),
        .dmem_badmem_e      (dmem_badmem_e),
        .bus_req_valid      (bus_req_valid),
        .bus_req_ready      (bus_req_ready),
        .bus_req_wen        (bus_req_wen),
        .bus_req_addr       (bus_req_addr),
        .bus_req_wstrb      (bus_req_wstrb),
        .bus_req_wdata      (bus_req_wdata),
        .bus_resp_valid     (bus_resp_valid),
        .bus_resp_rdata     (bus_resp_rdata),
        .bus_resp_err       (bus_resp_err)
    );

    typedef struct {
        logic        wen;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rresp;
        logic        err;
        int          rdly;
        int          pdly;
        logic        mis;
        logic [31:0] eaddr;
        logic [3:0]  estrb;
        logic [31:0] ewdata;
        logic [31:0] erdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic wen, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rresp, input logic err,
                                input int rdly, input int pdly, input logic mis,
                                input logic [31:0] eaddr, input logic [3:0] estrb,
                                input logic [31:0] ewdata, input logic [31:0] erdata);
        vec_t v;
        v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata;
        v.rresp = rresp; v.err = err; v.rdly = rdly; v.pdly = pdly;
        v.mis = mis; v.eaddr = eaddr; v.estrb = estrb;
        v.ewdata = ewdata; v.erdata = erdata;
        return v;
    endfunction

    // Reference model: byte counts, offsets and masks in plain arithmetic.
    function automatic vec_t model(input logic wen, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [31:0] rresp, input logic err,
                                   input int rdly, input int pdly);
        vec_t m;
        int nb;
        int off;
        logic [31:0] mask;
        logic [31:0] val;
        nb  = (size % 4 == 0) ? 1 : (size % 4 == 1) ? 2 : 4;
        off = int'(addr % 4);
        m = mk(wen, size, addr, wdata, rresp, err, rdly, pdly,
               1'b0, 32'd0, 4'd0, 32'd0, 32'd0);
        m.mis   = (off % nb) != 0;
        m.eaddr = addr - 32'(off);
        m.estrb = wen ? 4'(((1 << nb) - 1) << off) : 4'd0;
        if (nb == 1) m.ewdata = 32'(wdata[7:0] * 32'h01010101);
        else if (nb == 2) m.ewdata = 32'(wdata[15:0] * 32'h00010001);
        else m.ewdata = wdata;
        if (nb == 4) begin
            m.erdata = rresp;
        end else begin
            mask = 32'((64'd1 << (8 * nb)) - 64'd1);
            val  = (rresp >> (8 * off)) & mask;
            if (size < 4 && val[8 * nb - 1]) val = val | ~mask;
            m.erdata = val;
        end
        return m;
    endfunction

    task automatic idle_inputs();
        dmem_en = 1'b0;
        dmem_wen = 1'b0;
        dmem_size = 3'd0;
        dmem_addr = 32'd0;
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_err = 1'b0;
        bus_resp_rdata = 32'd0;
    endtask

    // Entered at posedge+1 with the DUT idle; leaves it idle the same way.
    task automatic run_txn(input vec_t v);
        int stalls;
        stalls = 0;
        dmem_en = 1'b1;
        dmem_wen = v.wen;
        dmem_size = v.size;
        dmem_addr = v.addr;
        dmem_wdata_delayed = $urandom;
        @(negedge clk);
        chk("accept_wait", 32'(dmem_wait), 32'd0);
        chk("accept_reqv", 32'(bus_req_valid), 32'd0);
        to_pos();
        dmem_en = 1'b0;
        dmem_addr = $urandom;
        dmem_size = 3'($urandom);
        dmem_wen = 1'($urandom);
        dmem_wdata_delayed = v.wdata;
        if (v.mis) begin
            @(negedge clk);
            chk("mis_reqv", 32'(bus_req_valid), 32'd0);
            chk("mis_wait", 32'(dmem_wait), 32'd0);
            chk("mis_bad", 32'(dmem_badmem_e), 32'd1);
            to_pos();
        end else begin
            for (int i = 0; i <= v.rdly; i++) begin
                bus_req_ready = (i == v.rdly);
                @(negedge clk);
                chk("req_valid", 32'(bus_req_valid), 32'd1);
                chk("req_wen", 32'(bus_req_wen), 32'(v.wen));
                chk("req_addr", bus_req_addr, v.eaddr);
                chk("req_wstrb", 32'(bus_req_wstrb), 32'(v.estrb));
                if (v.wen) chk("req_wdata", bus_req_wdata, v.ewdata);
                chk("req_wait", 32'(dmem_wait), 32'd1);
                stalls++;
                to_pos();
                bus_req_ready = 1'b0;
                dmem_wdata_delayed = $urandom;
            end
            for (int i = 0; i <= v.pdly; i++) begin
                bus_resp_valid = (i == v.pdly);
                bus_resp_rdata = (i == v.pdly) ? v.rresp : $urandom;
                bus_resp_err = (i == v.pdly) ? v.err : 1'($urandom);
                @(negedge clk);
                chk("resp_reqv", 32'(bus_req_valid), 32'd0);
                if (i < v.pdly) begin
                    chk("resp_wait", 32'(dmem_wait), 32'd1);
                    chk("resp_bad0", 32'(dmem_badmem_e), 32'd0);
                    chk("resp_hold", dmem_rdata, last_rdata);
                    stalls++;
                end else begin
                    chk("done_wait", 32'(dmem_wait), 32'd0);
                    chk("done_rdata", dmem_rdata, v.erdata);
                    chk("done_bad", 32'(dmem_badmem_e), 32'(v.err));
                    chk("stall_cnt", 32'(stalls), 32'(v.rdly + 1 + v.pdly));
                    last_rdata = v.erdata;
                end
                to_pos();
                bus_resp_valid = 1'b0;
                bus_resp_err = 1'b0;
            end
        end
        @(negedge clk);
        chk("idle_wait", 32'(dmem_wait), 32'd0);
        chk("idle_bad", 32'(dmem_badmem_e), 32'd0);
        chk("idle_rdata", dmem_rdata, last_rdata);
        to_pos();
    endtask

    vec_t vt[10];
    logic [2:0] sizes[5];

    initial begin
        vec_t r;
        logic [31:0] ra;
        logic [2:0] rs;

        sizes[0] = 3'd0; sizes[1] = 3'd1; sizes[2] = 3'd2;
        sizes[3] = 3'd4; sizes[4] = 3'd5;

        //      wen   sz    addr           wdata          rresp          err   rd pd mis   eaddr          strb     ewdata         erdata
        vt[0] = mk(1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1'b0, 0, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80);
        vt[1] = mk(1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1'b0, 0, 0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080);
        vt[2] = mk(1'b1, 3'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h1234_5678, 1'b0, 3, 0, 1'b0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0000_1234);
        vt[3] = mk(1'b0, 3'd2, 32'h0000_3002, 32'h0,        32'h0,        1'b0, 0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        vt[4] = mk(1'b1, 3'd1, 32'h0000_3001, 32'h0000_1111, 32'h0,        1'b0, 0, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0);
        vt[5] = mk(1'b0, 3'd1, 32'h0000_4000, 32'h0,        32'h0000_FFFE, 1'b1, 0, 0, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'hFFFF_FFFE);
        vt[6] = mk(1'b1, 3'd0, 32'h0000_5001, 32'h1234_56A5, 32'h0000_0000, 1'b0, 1, 2, 1'b0, 32'h0000_5000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000);
        vt[7] = mk(1'b0, 3'd5, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 1'b0, 0, 1, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,        32'h0000_8001);
        vt[8] = mk(1'b1, 3'd2, 32'h0000_7000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1, 1'b0, 32'h0000_7000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000);
        vt[9] = mk(1'b0, 3'd1, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 1'b0, 0, 0, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,        32'hFFFF_8001);

        idle_inputs();
        dmem_wdata_delayed = 32'd0;
        reset_n = 1'b0;
        to_pos();
        to_pos();
        @(negedge clk);
        chk("rst_reqv", 32'(bus_req_valid), 32'd0);
        chk("rst_wait", 32'(dmem_wait), 32'd0);
        chk("rst_bad", 32'(dmem_badmem_e), 32'd0);
        chk("rst_rdata", dmem_rdata, 32'd0);
        chk("rst_addr", bus_req_addr, 32'd0);
        chk("rst_wstrb", 32'(bus_req_wstrb), 32'd0);
        to_pos();
        reset_n = 1'b1;
        to_pos();

        for (int i = 0; i < 10; i++) run_txn(vt[i]);

        // Back-to-back: LW 0x10 completes while SW 0x20 is presented.
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h10;
        to_pos();
        dmem_en = 1'b0; bus_req_ready = 1'b1;
        @(negedge clk);
        chk("b2b_req1", bus_req_addr, 32'h10);
        to_pos();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFE_F00D;
        dmem_en = 1'b1; dmem_wen = 1'b1; dmem_size = 3'd2; dmem_addr = 32'h20;
        @(negedge clk);
        chk("b2b_wait", 32'(dmem_wait), 32'd0);
        chk("b2b_rdata", dmem_rdata, 32'hCAFE_F00D);
        to_pos();
        last_rdata = 32'hCAFE_F00D;
        bus_resp_valid = 1'b0; dmem_en = 1'b0;
        dmem_wdata_delayed = 32'h1122_3344;
        @(negedge clk);
        chk("b2b_reqv", 32'(bus_req_valid), 32'd1);
        chk("b2b_wen", 32'(bus_req_wen), 32'd1);
        chk("b2b_addr", bus_req_addr, 32'h20);
        chk("b2b_wdata", bus_req_wdata, 32'h1122_3344);
        to_pos();
        bus_req_ready = 1'b1;
        to_pos();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0;
        @(negedge clk);
        chk("b2b_done", 32'(dmem_wait), 32'd0);
        to_pos();
        last_rdata = 32'h0;
        idle_inputs();
        to_pos();

        // Reset while in REQ, then a stray response.
        dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h40;
        to_pos();
        dmem_en = 1'b0;
        @(negedge clk);
        chk("rstm_reqv", 32'(bus_req_valid), 32'd1);
        to_pos();
        reset_n = 1'b0;
        to_pos();
        reset_n = 1'b1;
        bus_resp_valid = 1'b1; bus_resp_err = 1'b1; bus_resp_rdata = 32'h8765_4321;
        @(negedge clk);
        chk("rstm_reqv0", 32'(bus_req_valid), 32'd0);
        chk("rstm_wait", 32'(dmem_wait), 32'd0);
        chk("rstm_bad", 32'(dmem_badmem_e), 32'd0);
        chk("rstm_rdata", dmem_rdata, 32'd0);
        to_pos();
        idle_inputs();
        @(negedge clk);
        chk("stray_reqv", 32'(bus_req_valid), 32'd0);
        chk("stray_rdata", dmem_rdata, 32'd0);
        to_pos();
        last_rdata = 32'd0;

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            rs = sizes[$urandom_range(0, 4)];
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rs[1:0] == 2'd1) ra[0] = 1'b0;
                if (rs[1:0] == 2'd2) ra[1:0] = 2'd0;
            end
            r = model(1'($urandom), rs, ra, $urandom, $urandom,
                      1'($urandom_range(0, 4) == 0),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            run_txn(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
